ex_operand_stage: RTL

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ex_operand_stage.sv
// -----------------------------------------------------------------------------
// ex_operand_stage
//
// ID/EX pipeline register with the hazard logic of a classic 5-stage RISC
// pipeline:
//   * load-use hazard detection, which produces 'stall' (holds PC and IF/ID)
//     and inserts exactly one bubble into EX,
//   * flush handling (taken branch/jump resolved in EX), which squashes the
//     instruction in ID. Flush wins over stall,
//   * operand-forwarding select codes for the two EX operand 3:1 muxes,
//     computed combinationally from the registered EX source indices,
//   * saturating stall and bubble performance counters.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   id_valid                       ID slot holds a real instruction
//   id_rs1/id_rs2/id_rd            ID register indices
//   id_rd1/id_rd2/id_imm/id_pc     ID operands, immediate and PC
//   id_ctrl                        opaque EX/MEM/WB control bundle
//   id_reg_write/id_mem_read       ID writeback / load flags
//   mem_rd/mem_reg_write           destination of the instruction in MEM
//   wb_rd/wb_reg_write             destination of the instruction in WB
//   flush                          squash the ID instruction this edge
//   ex_*                           registered EX-stage fields
//   fwd_a/fwd_b                    00 = register file, 01 = WB, 10 = MEM
//   stall                          hold PC and IF/ID this cycle
//   stall_cnt/bubble_cnt           saturating performance counters
// -----------------------------------------------------------------------------
module ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,

    input  logic [4:0]        mem_rd,
    input  logic              mem_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic              wb_reg_write,

    input  logic              flush,

    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_rd1,
    output logic [XLEN-1:0]   ex_rd2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,

    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // -------------------------------------------------------------------------
    // EX register layout. A bubble is simply the all-zero value of this struct.
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
    } ex_reg_t;

    localparam ex_reg_t          BUBBLE  = '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Forwarding select codes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    ex_reg_t          r_ex;
    ex_reg_t          w_id_fields;
    ex_reg_t          w_ex_next;
    logic             w_load_use;
    logic             w_stall;
    logic             w_insert_bubble;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // -------------------------------------------------------------------------
    // Forwarding select for one EX source index. MEM is younger than WB, so it
    // wins when both write the same register. x0 is hard-wired zero and is
    // never forwarded.
    // -------------------------------------------------------------------------
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            return FWD_MEM;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

    // -------------------------------------------------------------------------
    // Hazard detection.
    // A load sitting in EX whose destination is read by the instruction in ID
    // cannot be forwarded in time. The bubble it causes has mem_read=0, so the
    // hazard clears by itself one cycle later. A flush discards the ID
    // instruction anyway, so it suppresses the stall.
    // -------------------------------------------------------------------------
    always_comb begin
        w_load_use = r_ex.valid && r_ex.mem_read && (r_ex.rd != 5'd0) && id_valid
                  && ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2));
        w_stall         = w_load_use && !flush;
        w_insert_bubble = flush || w_stall;
    end

    // -------------------------------------------------------------------------
    // Next EX register value.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the block
        // leaves a value unassigned and no latch is inferred.
        w_id_fields           = BUBBLE;
        w_id_fields.valid     = id_valid;
        w_id_fields.reg_write = id_reg_write;
        w_id_fields.mem_read  = id_mem_read;
        w_id_fields.rs1       = id_rs1;
        w_id_fields.rs2       = id_rs2;
        w_id_fields.rd        = id_rd;
        w_id_fields.rd1       = id_rd1;
        w_id_fields.rd2       = id_rd2;
        w_id_fields.imm       = id_imm;
        w_id_fields.pc        = id_pc;
        w_id_fields.ctrl      = id_ctrl;

        w_ex_next = w_insert_bubble ? BUBBLE : w_id_fields;
    end

    // -------------------------------------------------------------------------
    // EX register. Reset overrides flush and stall.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_ex <= BUBBLE;
        end else begin
            r_ex <= w_ex_next;
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters, saturating at all-ones.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_insert_bubble && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Forwarding: zero-latency, from the registered EX source indices. An empty
    // EX slot always selects the register file.
    // -------------------------------------------------------------------------
    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (r_ex.valid) begin
            w_fwd_a = fwd_select(r_ex.rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
            w_fwd_b = fwd_select(r_ex.rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ex_valid     = r_ex.valid;
    assign ex_reg_write = r_ex.reg_write;
    assign ex_mem_read  = r_ex.mem_read;
    assign ex_rs1       = r_ex.rs1;
    assign ex_rs2       = r_ex.rs2;
    assign ex_rd        = r_ex.rd;
    assign ex_rd1       = r_ex.rd1;
    assign ex_rd2       = r_ex.rd2;
    assign ex_imm       = r_ex.imm;
    assign ex_pc        = r_ex.pc;
    assign ex_ctrl      = r_ex.ctrl;

    assign fwd_a        = w_fwd_a;
    assign fwd_b        = w_fwd_b;
    assign stall        = w_stall;
    assign stall_cnt    = r_stall_cnt;
    assign bubble_cnt   = r_bubble_cnt;

endmodule
